ib_dispatch_ctrl: RTL and testbench

Instruction buffer and in-order dispatch controller for the 2-way front end. It queues fetched IBEntry_t entries and presents the oldest two to the two decoder instances. Using each decoder's de_fuType, destination and control flags, plus back-end free counts, it decides how many of the two decoded instructions dispatch this cycle. It also sequences halt, illegal-instruction stop and flush recovery.

---
 rtl/ib_dispatch_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ib_dispatch_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ib_dispatch_ctrl.sv
// Instruction buffer and 2-wide in-order dispatch controller: queues fetched entries,
// feeds the two decoders, and decides each cycle how many decoded slots dispatch.
package ib_dispatch_pkg;
  typedef enum logic [1:0] {
    FUT_ALU  = 2'd0,
    FUT_MULT = 2'd1,
    FUT_BR   = 2'd2,
    FUT_LDST = 2'd3
  } FU_TYPE;

  typedef logic [4:0] ARCH_REG;
  localparam ARCH_REG ZERO_REG = 5'd31;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } IBEntry_t;
endpackage

module ib_dispatch_ctrl
  import ib_dispatch_pkg::*;
#(
  parameter int IB_DEPTH = 8,
  parameter int CNT_W    = $clog2(IB_DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [1:0]           if_valid,
  input  IBEntry_t [1:0]       if_data,
  output logic [1:0]           ib_space,
  output logic [1:0]           ib_valid,
  output IBEntry_t [1:0]       ib_data,
  input  FU_TYPE [1:0]         de_fuType,
  input  ARCH_REG [1:0]        de_destidx,
  input  logic [1:0]           de_halt,
  input  logic [1:0]           de_illegal,
  input  logic [1:0]           de_noop,
  input  logic [1:0]           rob_free,
  input  logic [1:0]           fl_free,
  input  logic [1:0]           rs_alu_free,
  input  logic [1:0]           rs_mult_free,
  input  logic [1:0]           rs_br_free,
  input  logic [1:0]           rs_ldst_free,
  output logic [1:0]           dispatch_en,
  output logic [CNT_W-1:0]     count,
  output logic                 halted,
  output logic                 illegal_stop
);
  localparam int PTR_W = $clog2(IB_DEPTH);

  typedef enum logic [1:0] {S_RUN, S_HALTED, S_ILLEGAL} state_t;

  state_t           state, state_next;
  logic [PTR_W-1:0] head, tail;
  IBEntry_t         mem [IB_DEPTH];

  logic             run;
  logic [CNT_W-1:0] room;
  logic [1:0]       n_fetch, enq, deq;
  logic             halt_go;
  logic [1:0]       fl_need, rs_need;
  logic [1:0]       rs_free [4];
  logic [1:0]       fl_sum, rs_use0, rs_use1;
  logic             same_type, fit0, fit01, br_pair;

  assign run          = (state == S_RUN);
  assign halted       = (state == S_HALTED);
  assign illegal_stop = (state == S_ILLEGAL);

  // Advertised space looks only at the registered count, never at this cycle's dispatch.
  assign room     = CNT_W'(IB_DEPTH) - count;
  assign ib_space = !run ? 2'd0 : (room >= CNT_W'(2)) ? 2'd2 : room[1:0];

  assign ib_valid[0] = run && (count > CNT_W'(0));
  assign ib_valid[1] = run && (count > CNT_W'(1));
  assign ib_data[0]  = mem[head];
  assign ib_data[1]  = mem[head + PTR_W'(1)];

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    rs_free[0] = rs_alu_free;
    rs_free[1] = rs_mult_free;
    rs_free[2] = rs_br_free;
    rs_free[3] = rs_ldst_free;

    for (int i = 0; i < 2; i++) begin
      fl_need[i] = (de_destidx[i] != ZERO_REG) && !de_noop[i];
      rs_need[i] = !(de_noop[i] || de_halt[i]);
    end

    same_type = (de_fuType[0] == de_fuType[1]);
    fl_sum    = 2'(fl_need[0]) + 2'(fl_need[1]);
    rs_use0   = 2'(rs_need[0]) + 2'(rs_need[1] && same_type);
    rs_use1   = 2'(rs_need[1]) + 2'(rs_need[0] && same_type);

    fit0  = (rob_free >= 2'd1) && (fl_free >= 2'(fl_need[0]))
         && (rs_free[de_fuType[0]] >= 2'(rs_need[0]));
    fit01 = (rob_free >= 2'd2) && (fl_free >= fl_sum)
         && (rs_free[de_fuType[0]] >= rs_use0)
         && (rs_free[de_fuType[1]] >= rs_use1);
    br_pair = (de_fuType[0] == FUT_BR) && (de_fuType[1] == FUT_BR);

    dispatch_en    = 2'b00;
    dispatch_en[0] = !flush && ib_valid[0] && !de_illegal[0] && fit0;
    dispatch_en[1] = dispatch_en[0] && ib_valid[1] && !de_illegal[1]
                  && !de_halt[0] && fit01 && !br_pair;

    deq     = 2'(dispatch_en[0]) + 2'(dispatch_en[1]);
    halt_go = (dispatch_en[0] && de_halt[0]) || (dispatch_en[1] && de_halt[1]);

    n_fetch = if_valid[1] ? 2'd2 : {1'b0, if_valid[0]};
    enq     = (n_fetch < ib_space) ? n_fetch : ib_space;
    if (flush || halt_go) enq = 2'd0;

    state_next = state;
    if (flush) begin
      state_next = S_RUN;
    end else begin
      unique case (state)
        S_RUN: begin
          if (halt_go)                          state_next = S_HALTED;
          else if (ib_valid[0] && de_illegal[0]) state_next = S_ILLEGAL;
        end
        S_HALTED, S_ILLEGAL: state_next = state;
        default:             state_next = S_RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_RUN;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else if (halt_go) begin
        // Everything younger than the halt is discarded.
        head  <= tail;
        count <= '0;
      end else begin
        head  <= head + PTR_W'(deq);
        tail  <= tail + PTR_W'(enq);
        count <= count + CNT_W'(enq) - CNT_W'(deq);
      end
    end
  end

  // NOTE: buffer storage is not reset; count/ib_valid gate every read of stale data.
  always_ff @(posedge clock) begin
    if (enq != 2'd0) mem[tail] <= if_data[0];
    if (enq == 2'd2) mem[tail + PTR_W'(1)] <= if_data[1];
  end

endmodule

// File: tb/tb_ib_dispatch_ctrl.sv
// Directed-vector bench for ib_dispatch_ctrl: fill/drain, resource split, branch pairing,
// halt, illegal stop, pointer wrap, flush and asynchronous reset.
module tb_ib_dispatch_ctrl;
  import ib_dispatch_pkg::*;

  logic           clock = 1'b0;
  logic           reset;
  logic           flush;
  logic [1:0]     if_valid;
  IBEntry_t [1:0] if_data;
  logic [1:0]     ib_space;
  logic [1:0]     ib_valid;
  IBEntry_t [1:0] ib_data;
  FU_TYPE [1:0]   de_fuType;
  ARCH_REG [1:0]  de_destidx;
  logic [1:0]     de_halt, de_illegal, de_noop;
  logic [1:0]     rob_free, fl_free;
  logic [1:0]     rs_alu_free, rs_mult_free, rs_br_free, rs_ldst_free;
  logic [1:0]     dispatch_en;
  logic [3:0]     count;
  logic           halted, illegal_stop;

  int vec_cnt = 0;
  int err_cnt = 0;

  ib_dispatch_ctrl #(.IB_DEPTH(8)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .if_valid(if_valid), .if_data(if_data),
    .ib_space(ib_space), .ib_valid(ib_valid), .ib_data(ib_data),
    .de_fuType(de_fuType), .de_destidx(de_destidx),
    .de_halt(de_halt), .de_illegal(de_illegal), .de_noop(de_noop),
    .rob_free(rob_free), .fl_free(fl_free),
    .rs_alu_free(rs_alu_free), .rs_mult_free(rs_mult_free),
    .rs_br_free(rs_br_free), .rs_ldst_free(rs_ldst_free),
    .dispatch_en(dispatch_en), .count(count),
    .halted(halted), .illegal_stop(illegal_stop)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_defaults();
    flush        = 1'b0;
    if_valid     = 2'b00;
    if_data      = '0;
    de_fuType[0] = FUT_ALU;
    de_fuType[1] = FUT_ALU;
    de_destidx[0] = 5'd1;
    de_destidx[1] = 5'd2;
    de_halt      = 2'b00;
    de_illegal   = 2'b00;
    de_noop      = 2'b00;
    rob_free     = 2'd2;
    fl_free      = 2'd2;
    rs_alu_free  = 2'd2;
    rs_mult_free = 2'd2;
    rs_br_free   = 2'd2;
    rs_ldst_free = 2'd2;
  endtask

  task automatic fetch(input logic [1:0] v, input int id0);
    if_valid   = v;
    if_data[0] = '{pc: 32'(id0),     inst: 32'h13};
    if_data[1] = '{pc: 32'(id0 + 1), inst: 32'h13};
  endtask

  task automatic test_reset();
    vec_cnt++;
    if (count !== 4'd0) begin err_cnt++; $display("FAIL reset_count: got %0d want 0", count); end
    vec_cnt++;
    if (ib_valid !== 2'b00 || dispatch_en !== 2'b00) begin
      err_cnt++; $display("FAIL reset_valid_disp: got %b/%b want 00/00", ib_valid, dispatch_en);
    end
    vec_cnt++;
    if (halted !== 1'b0 || illegal_stop !== 1'b0) begin
      err_cnt++; $display("FAIL reset_flags: got halted=%b illegal=%b want 0/0", halted, illegal_stop);
    end
    vec_cnt++;
    if (ib_space !== 2'd2) begin err_cnt++; $display("FAIL reset_space: got %0d want 2", ib_space); end
  endtask

  task automatic test_fill_drain();
    set_defaults();
    fetch(2'b11, 0); #1;
    vec_cnt++;
    if (dispatch_en !== 2'b00) begin err_cnt++; $display("FAIL fill_empty_disp: got %b want 00", dispatch_en); end
    tick();
    for (int k = 0; k < 3; k++) begin
      fetch(2'b11, 2 + 2 * k); #1;
      vec_cnt++;
      if (dispatch_en !== 2'b11 || ib_data[0].pc !== 32'(2 * k) || ib_data[1].pc !== 32'(2 * k + 1)) begin
        err_cnt++;
        $display("FAIL steady_c%0d: got disp=%b pcs=%0d,%0d want 11 %0d,%0d",
                 k, dispatch_en, ib_data[0].pc, ib_data[1].pc, 2 * k, 2 * k + 1);
      end
      tick();
      vec_cnt++;
      if (count !== 4'd2) begin err_cnt++; $display("FAIL steady_count_c%0d: got %0d want 2", k, count); end
    end
    rs_alu_free = 2'd0; rs_mult_free = 2'd0; rs_br_free = 2'd0; rs_ldst_free = 2'd0;
    for (int k = 0; k < 3; k++) begin
      fetch(2'b11, 8 + 2 * k); #1;
      vec_cnt++;
      if (dispatch_en !== 2'b00) begin err_cnt++; $display("FAIL stall_disp_c%0d: got %b want 00", k, dispatch_en); end
      tick();
    end
    fetch(2'b11, 14); #1;
    vec_cnt++;
    if (count !== 4'd8 || ib_space !== 2'd0) begin
      err_cnt++; $display("FAIL full: got count=%0d space=%0d want 8/0", count, ib_space);
    end
    tick();
    vec_cnt++;
    if (count !== 4'd8 || ib_data[0].pc !== 32'd6 || ib_data[1].pc !== 32'd7) begin
      err_cnt++;
      $display("FAIL full_no_overwrite: got count=%0d pcs=%0d,%0d want 8 6,7", count, ib_data[0].pc, ib_data[1].pc);
    end
    set_defaults();
    for (int k = 0; k < 4; k++) begin
      #1;
      vec_cnt++;
      if (dispatch_en !== 2'b11 || ib_data[0].pc !== 32'(6 + 2 * k) || ib_data[1].pc !== 32'(7 + 2 * k)) begin
        err_cnt++;
        $display("FAIL drain_c%0d: got disp=%b pcs=%0d,%0d want 11 %0d,%0d",
                 k, dispatch_en, ib_data[0].pc, ib_data[1].pc, 6 + 2 * k, 7 + 2 * k);
      end
      tick();
    end
    vec_cnt++;
    if (count !== 4'd0) begin err_cnt++; $display("FAIL drain_count: got %0d want 0", count); end
  endtask

  task automatic test_resource_split();
    set_defaults();
    rs_alu_free = 2'd0;
    fetch(2'b11, 20); tick();
    fetch(2'b11, 22); #1;
    vec_cnt++;
    if (dispatch_en !== 2'b00) begin err_cnt++; $display("FAIL split_stall: got %b want 00", dispatch_en); end
    tick();
    if_valid = 2'b00; rs_alu_free = 2'd1; #1;
    vec_cnt++;
    if (dispatch_en !== 2'b01) begin err_cnt++; $display("FAIL split_one_alu: got %b want 01", dispatch_en); end
    tick();
    rs_alu_free = 2'd2; #1;
    vec_cnt++;
    if (dispatch_en !== 2'b11 || ib_data[0].pc !== 32'd21 || ib_data[1].pc !== 32'd22) begin
      err_cnt++;
      $display("FAIL split_pair_wrap: got disp=%b pcs=%0d,%0d want 11 21,22", dispatch_en, ib_data[0].pc, ib_data[1].pc);
    end
    tick();
    de_destidx[0] = ZERO_REG; fl_free = 2'd0; #1;
    vec_cnt++;
    if (ib_valid !== 2'b01 || dispatch_en !== 2'b01 || ib_data[0].pc !== 32'd23) begin
      err_cnt++;
      $display("FAIL split_zero_dest: got valid=%b disp=%b pc=%0d want 01 01 23", ib_valid, dispatch_en, ib_data[0].pc);
    end
    tick();
  endtask

  task automatic test_branch_pair();
    set_defaults();
    fetch(2'b11, 30); tick();
    if_valid = 2'b00;
    de_fuType[0] = FUT_BR; de_fuType[1] = FUT_BR; #1;
    vec_cnt++;
    if (dispatch_en !== 2'b01) begin err_cnt++; $display("FAIL br_pair: got %b want 01", dispatch_en); end
    tick();
    #1;
    vec_cnt++;
    if (dispatch_en !== 2'b01 || ib_data[0].pc !== 32'd31) begin
      err_cnt++; $display("FAIL br_second: got disp=%b pc=%0d want 01 31", dispatch_en, ib_data[0].pc);
    end
    tick();
  endtask

  task automatic test_halt();
    set_defaults();
    fetch(2'b11, 40); tick();
    fetch(2'b11, 42); de_halt = 2'b01; #1;
    vec_cnt++;
    if (dispatch_en !== 2'b01) begin err_cnt++; $display("FAIL halt_disp: got %b want 01", dispatch_en); end
    tick();
    de_halt = 2'b00; #1;
    vec_cnt++;
    if (halted !== 1'b1 || count !== 4'd0 || ib_space !== 2'd0 || dispatch_en !== 2'b00) begin
      err_cnt++;
      $display("FAIL halt_state: got halted=%b count=%0d space=%0d disp=%b want 1 0 0 00",
               halted, count, ib_space, dispatch_en);
    end
    flush = 1'b1; tick();
    flush = 1'b0; if_valid = 2'b00; #1;
    vec_cnt++;
    if (halted !== 1'b0 || ib_space !== 2'd2 || count !== 4'd0) begin
      err_cnt++; $display("FAIL halt_flush: got halted=%b space=%0d count=%0d want 0 2 0", halted, ib_space, count);
    end
  endtask

  task automatic test_illegal();
    set_defaults();
    fetch(2'b11, 50); tick();
    if_valid = 2'b00; de_illegal = 2'b10; #1;
    vec_cnt++;
    if (dispatch_en !== 2'b01) begin err_cnt++; $display("FAIL ill_slot1_disp: got %b want 01", dispatch_en); end
    tick();
    de_illegal = 2'b01; #1;
    vec_cnt++;
    if (dispatch_en !== 2'b00 || ib_data[0].pc !== 32'd51 || illegal_stop !== 1'b0) begin
      err_cnt++;
      $display("FAIL ill_head: got disp=%b pc=%0d stop=%b want 00 51 0", dispatch_en, ib_data[0].pc, illegal_stop);
    end
    tick();
    de_illegal = 2'b00; #1;
    vec_cnt++;
    if (illegal_stop !== 1'b1 || count !== 4'd1 || dispatch_en !== 2'b00 || ib_space !== 2'd0) begin
      err_cnt++;
      $display("FAIL ill_stop: got stop=%b count=%0d disp=%b space=%0d want 1 1 00 0",
               illegal_stop, count, dispatch_en, ib_space);
    end
    flush = 1'b1; tick();
    flush = 1'b0; #1;
    vec_cnt++;
    if (illegal_stop !== 1'b0 || count !== 4'd0) begin
      err_cnt++; $display("FAIL ill_flush: got stop=%b count=%0d want 0 0", illegal_stop, count);
    end
  endtask

  task automatic test_wrap_flush_reset();
    set_defaults();
    fetch(2'b11, 60); tick();
    fetch(2'b11, 62); tick();
    fetch(2'b11, 64); tick();
    fetch(2'b01, 66); tick();
    fetch(2'b11, 67); #1;
    vec_cnt++;
    if (dispatch_en !== 2'b01 || ib_data[0].pc !== 32'd66) begin
      err_cnt++; $display("FAIL wrap_pre: got disp=%b pc=%0d want 01 66", dispatch_en, ib_data[0].pc);
    end
    tick();
    if_valid = 2'b00; #1;
    vec_cnt++;
    if (dispatch_en !== 2'b11 || ib_data[0].pc !== 32'd67 || ib_data[1].pc !== 32'd68) begin
      err_cnt++;
      $display("FAIL wrap_deq: got disp=%b pcs=%0d,%0d want 11 67,68", dispatch_en, ib_data[0].pc, ib_data[1].pc);
    end
    tick();
    vec_cnt++;
    if (count !== 4'd0) begin err_cnt++; $display("FAIL wrap_count: got %0d want 0", count); end
    fetch(2'b11, 70); tick();
    fetch(2'b11, 72); flush = 1'b1; #1;
    vec_cnt++;
    if (dispatch_en !== 2'b00) begin err_cnt++; $display("FAIL flush_disp: got %b want 00", dispatch_en); end
    tick();
    flush = 1'b0; if_valid = 2'b00; #1;
    vec_cnt++;
    if (count !== 4'd0 || ib_valid !== 2'b00) begin
      err_cnt++; $display("FAIL flush_clear: got count=%0d valid=%b want 0 00", count, ib_valid);
    end
    rs_alu_free = 2'd0;
    fetch(2'b11, 80); tick();
    fetch(2'b11, 82); tick();
    if_valid = 2'b00; rs_alu_free = 2'd2; #1;
    vec_cnt++;
    if (count !== 4'd4 || dispatch_en !== 2'b11) begin
      err_cnt++; $display("FAIL prereset: got count=%0d disp=%b want 4 11", count, dispatch_en);
    end
    reset = 1'b0; #1;
    vec_cnt++;
    if (count !== 4'd0 || dispatch_en !== 2'b00 || ib_valid !== 2'b00) begin
      err_cnt++;
      $display("FAIL async_reset: got count=%0d disp=%b valid=%b want 0 00 00", count, dispatch_en, ib_valid);
    end
    #1 reset = 1'b1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    set_defaults();
    #12;
    test_reset();
    @(negedge clock);
    reset = 1'b1;
    tick();
    test_fill_drain();
    test_resource_split();
    test_branch_pair();
    test_halt();
    test_illegal();
    test_wrap_flush_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
